// File: rtl/dropout_grad_mask.sv
// dropout_grad_mask: buffers forward-pass drop masks in a small FIFO and
// replays them, in order, onto incoming gradient vectors. Dropped lanes are
// zeroed, kept lanes are scaled by SCALE_Q (unsigned Q4.4) with saturation.
module dropout_grad_mask #(
  parameter int          N       = 8,
  parameter int          W       = 8,
  parameter int          DEPTH   = 4,
  parameter logic [7:0]  SCALE_Q = 8'h20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         mask_valid,
  output logic                         mask_ready,
  input  logic [N-1:0]                 mask_in,
  input  logic                         grad_valid,
  output logic                         grad_ready,
  input  logic [N*W-1:0]               grad_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*W-1:0]               grad_out,
  output logic [$clog2(DEPTH+1)-1:0]   mask_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           out_valid_q, out_valid_d;
  logic [N*W-1:0] grad_out_q, grad_out_d;
  logic [N*W-1:0] result;
  logic [N-1:0]   mask_head;
  logic           push, pop;

  // Kept-lane arithmetic: signed product, floor shift by 4, clamp to W bits.
  function automatic logic [W-1:0] scale_lane(input logic [W-1:0] g);
    logic signed [W+8:0] prod;
    logic signed [W+8:0] shr;
    prod = $signed({{9{g[W-1]}}, g}) * $signed({{W{1'b0}}, 1'b0, SCALE_Q});
    shr  = prod >>> 4;
    if (!shr[W+8] && (|shr[W+7:W-1]))
      return {1'b0, {(W-1){1'b1}}};
    else if (shr[W+8] && !(&shr[W+7:W-1]))
      return {1'b1, {(W-1){1'b0}}};
    else
      return shr[W-1:0];
  endfunction

  assign mask_ready = (count_q < DEPTH_C) && !reset;
  assign grad_ready = (count_q != '0) && (!out_valid_q || out_ready) && !flush && !reset;
  assign push       = mask_valid && mask_ready && !flush;
  assign pop        = grad_valid && grad_ready;
  assign mask_head  = mem_q[rd_ptr_q];
  assign out_valid  = out_valid_q;
  assign grad_out   = grad_out_q;
  assign mask_count = count_q;

  // Apply the head mask and scaling to every lane of the incoming gradient.
  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < N; i++) begin
      result[i*W +: W] = mask_head[i] ? '0 : scale_lane(grad_in[i*W +: W]);
    end
  end

  // FIFO pointer/count and output-stage next state; flush overrides all.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    grad_out_d  = grad_out_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (pop) begin
        out_valid_d = 1'b1;
        grad_out_d  = result;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      grad_out_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      grad_out_q  <= grad_out_d;
    end
  end

  // Mask storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mask_in;
  end

endmodule

// File: tb/tb_dropout_grad_mask.sv
// Self-checking bench for dropout_grad_mask: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_dropout_grad_mask;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic            mask_valid, mask_ready;
  logic [N-1:0]    mask_in;
  logic            grad_valid, grad_ready;
  logic [N*W-1:0]  grad_in;
  logic            out_valid, out_ready;
  logic [N*W-1:0]  grad_out;
  logic [2:0]      mask_count;

  int tests  = 0;
  int failed = 0;

  logic [7:0]  mq[$];
  logic        ev;
  logic [63:0] ed;

  always #5 clk = ~clk;

  dropout_grad_mask #(.N(N), .W(W), .DEPTH(DEPTH), .SCALE_Q(8'h20)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_in(mask_in),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .out_valid(out_valid), .out_ready(out_ready), .grad_out(grad_out),
    .mask_count(mask_count)
  );

  // Reference: kept lane = floor(g * 32 / 16) clamped to [-128, 127].
  function automatic logic [63:0] ref_vec(input logic [7:0] m, input logic [63:0] g);
    logic [63:0] res;
    int gv, v, r;
    res = '0;
    for (int i = 0; i < N; i++) begin
      gv = int'($signed(g[i*8 +: 8]));
      v  = gv * 32;
      r  = (v >= 0) ? v / 16 : -((-v + 15) / 16);
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      res[i*8 +: 8] = m[i] ? 8'h00 : r[7:0];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the model, then advance the model.
  task automatic cycle(input string tag);
    bit mr, gr, push, pop;
    #1;
    mr = (mq.size() < DEPTH);
    gr = (mq.size() != 0) && (!ev || out_ready) && !flush;
    chk({tag, ".mask_ready"}, 64'(mask_ready), 64'(mr));
    chk({tag, ".grad_ready"}, 64'(grad_ready), 64'(gr));
    chk({tag, ".mask_count"}, 64'(mask_count), 64'(mq.size()));
    chk({tag, ".out_valid"},  64'(out_valid),  64'(ev));
    if (ev) chk({tag, ".grad_out"}, grad_out, ed);
    push = mask_valid && mr && !flush;
    pop  = grad_valid && gr;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      ev = 1'b0;
    end else begin
      if (pop) begin
        ed = ref_vec(mq.pop_front(), grad_in);
        ev = 1'b1;
      end else if (out_ready) begin
        ev = 1'b0;
      end
      if (push) mq.push_back(mask_in);
    end
    @(negedge clk);
  endtask

  task automatic rand_grad();
    grad_in = {$urandom(), $urandom()};
  endtask

  initial begin
    logic [63:0] held;
    reset = 1'b1; flush = 1'b0; mask_valid = 1'b0; mask_in = '0;
    grad_valid = 1'b0; grad_in = '0; out_ready = 1'b1;
    mq.delete(); ev = 1'b0; ed = '0;
    repeat (2) @(negedge clk);
    chk("rst.mask_ready", 64'(mask_ready), 64'd0);
    chk("rst.grad_ready", 64'(grad_ready), 64'd0);
    chk("rst.out_valid",  64'(out_valid),  64'd0);
    chk("rst.mask_count", 64'(mask_count), 64'd0);
    chk("rst.grad_out",   grad_out,        64'd0);
    reset = 1'b0;

    // 1: basic mask replay
    mask_valid = 1'b1; mask_in = 8'b0000_0101;
    cycle("t1.push");
    mask_valid = 1'b0; grad_valid = 1'b1; grad_in = {8{8'd10}};
    cycle("t1.acc");
    grad_valid = 1'b0;
    #1;
    chk("t1.out_valid", 64'(out_valid), 64'd1);
    chk("t1.grad_out",  grad_out, 64'h1414_1414_1400_1400);
    cycle("t1.out");

    // 2: saturation and floor rounding
    mask_valid = 1'b1; mask_in = 8'h00;
    cycle("t2.push");
    mask_valid = 1'b0; grad_valid = 1'b1; grad_in = 64'h0000_00FF_C03F_9C64;
    cycle("t2.acc");
    grad_valid = 1'b0;
    #1;
    chk("t2.grad_out", grad_out, 64'h0000_00FE_807E_807F);
    cycle("t2.out");

    // 3: gradient stalls on an empty FIFO
    grad_valid = 1'b1; rand_grad();
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3.stall", 64'(grad_ready), 64'd0);
      cycle("t3.stall_cyc");
    end
    mask_valid = 1'b1; mask_in = 8'($urandom());
    cycle("t3.push");
    mask_valid = 1'b0;
    #1 chk("t3.go", 64'(grad_ready), 64'd1);
    cycle("t3.acc");
    grad_valid = 1'b0;
    cycle("t3.out");

    // 4: fill, hold fifth mask, push+pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      mask_valid = 1'b1; mask_in = 8'($urandom());
      cycle("t4.fill");
    end
    mask_in = 8'($urandom());
    #1;
    chk("t4.full_ready", 64'(mask_ready), 64'd4 - 64'd4);
    chk("t4.full_count", 64'(mask_count), 64'd4);
    cycle("t4.held");
    grad_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_grad();
      cycle("t4.pushpop");
      #1 chk("t4.count3", 64'(mask_count), 64'd3);
      mask_in = 8'($urandom());
    end
    mask_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_grad();
      cycle("t4.drain");
    end
    grad_valid = 1'b0;
    cycle("t4.idle");

    // 5: back-pressure holds output; release streams one per cycle
    for (int i = 0; i < 3; i++) begin
      mask_valid = 1'b1; mask_in = 8'($urandom());
      cycle("t5.fill");
    end
    mask_valid = 1'b0; grad_valid = 1'b1; rand_grad();
    cycle("t5.acc");
    out_ready = 1'b0;
    held = ed;
    for (int i = 0; i < 3; i++) begin
      rand_grad();
      #1;
      chk("t5.stable", grad_out, held);
      chk("t5.gready", 64'(grad_ready), 64'd0);
      cycle("t5.hold");
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_grad();
      cycle("t5.stream");
    end
    grad_valid = 1'b0;
    cycle("t5.tail");

    // 6: flush with masks queued and output pending
    for (int i = 0; i < 4; i++) begin
      mask_valid = 1'b1; mask_in = 8'($urandom());
      cycle("t6.fill");
    end
    mask_valid = 1'b0; out_ready = 1'b0; grad_valid = 1'b1; rand_grad();
    cycle("t6.acc");
    flush = 1'b1; mask_valid = 1'b1; grad_valid = 1'b1;
    cycle("t6.flush");
    flush = 1'b0; mask_valid = 1'b0; grad_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t6.count", 64'(mask_count), 64'd0);
    chk("t6.valid", 64'(out_valid), 64'd0);
    cycle("t6.after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush      = ($urandom_range(31) == 0);
      mask_valid = $urandom_range(1);
      mask_in    = 8'($urandom());
      grad_valid = $urandom_range(1);
      out_ready  = ($urandom_range(3) != 0);
      rand_grad();
      cycle("rnd");
    end

    // Async reset mid-stream
    flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mask_valid = 1'b1; mask_in = 8'($urandom()); grad_valid = (i == 2); rand_grad();
      cycle("ar.fill");
    end
    mask_valid = 1'b1; grad_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("ar.out_valid",  64'(out_valid),  64'd0);
    chk("ar.grad_out",   grad_out,        64'd0);
    chk("ar.mask_count", 64'(mask_count), 64'd0);
    chk("ar.mask_ready", 64'(mask_ready), 64'd0);
    chk("ar.grad_ready", 64'(grad_ready), 64'd0);
    mq.delete(); ev = 1'b0; ed = '0;
    @(negedge clk);
    reset = 1'b0; grad_valid = 1'b0; out_ready = 1'b1;
    mask_in = 8'hF0;
    cycle("ar.push");
    mask_valid = 1'b0; grad_valid = 1'b1; grad_in = {8{8'hFD}};
    cycle("ar.acc");
    grad_valid = 1'b0;
    #1 chk("ar.first", grad_out, 64'h0000_0000_FAFA_FAFA);
    for (int i = 0; i < 100; i++) begin
      mask_valid = $urandom_range(1);
      mask_in    = 8'($urandom());
      grad_valid = $urandom_range(1);
      out_ready  = $urandom_range(1);
      rand_grad();
      cycle("rnd2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
